// File: rtl/imem_encoder_if.sv
// Bus bundle for the instruction encoder/loader.
// slave  : encoder side (takes instruction fields and pointer loads, drives byte writes and status)
// master : producer/consumer side (drives instruction fields and pointer loads, observes writes)
// Signals: load_en/load_addr (write pointer load), in_valid/in_ready + in_icode/in_ifun/in_rA/in_rB/in_valC
//          (instruction handshake), mem_we/mem_addr/mem_wdata (byte write port), wr_ptr, done, enc_err.
interface imem_encoder_if #(
   parameter int unsigned N  = 64,
   parameter int unsigned AW = 10
);
   logic          load_en;
   logic [N-1:0]  load_addr;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_icode;
   logic [3:0]    in_ifun;
   logic [3:0]    in_rA;
   logic [3:0]    in_rB;
   logic [N-1:0]  in_valC;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [N-1:0]  wr_ptr;
   logic          done;
   logic          enc_err;

   modport slave (
      input  load_en, load_addr, in_valid, in_icode, in_ifun, in_rA, in_rB, in_valC,
      output in_ready, mem_we, mem_addr, mem_wdata, wr_ptr, done, enc_err
   );

   modport master (
      output load_en, load_addr, in_valid, in_icode, in_ifun, in_rA, in_rB, in_valC,
      input  in_ready, mem_we, mem_addr, mem_wdata, wr_ptr, done, enc_err
   );
endinterface

// File: rtl/imem_encoder.sv
// Y86-64 instruction encoder/loader: serializes one decoded instruction into 1..10 bytes and
// writes them one per cycle into a 1024-byte instruction memory, in the layout fetch decodes.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   io_enc  - imem_encoder_if.slave: instruction handshake, pointer load, byte write port, status
module imem_encoder (
   input  logic           clk,
   input  logic           rst_n,
   imem_encoder_if.slave  io_enc
);
   localparam int unsigned N         = 64;
   localparam int unsigned AW        = 10;
   localparam int unsigned MEM_BYTES = 1024;
   localparam int unsigned LW        = 4;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t        r_state,     w_state_nxt;
   logic [N-1:0]  r_wr_ptr,    w_wr_ptr_nxt;
   logic [N-1:0]  r_base,      w_base_nxt;
   logic [LW-1:0] r_len,       w_len_nxt;
   logic [LW-1:0] r_idx,       w_idx_nxt;
   logic [3:0]    r_icode,     w_icode_nxt;
   logic [3:0]    r_ifun,      w_ifun_nxt;
   logic [3:0]    r_ra,        w_ra_nxt;
   logic [3:0]    r_rb,        w_rb_nxt;
   logic [N-1:0]  r_valc,      w_valc_nxt;
   logic          r_mem_we,    w_mem_we_nxt;
   logic [AW-1:0] r_mem_addr,  w_mem_addr_nxt;
   logic [7:0]    r_mem_wdata, w_mem_wdata_nxt;
   logic          r_done,      w_done_nxt;
   logic          r_enc_err,   w_enc_err_nxt;

   logic [LW-1:0] w_in_len;
   logic [N:0]    w_in_end;
   logic [LW-1:0] w_idx_inc;
   logic          w_accept;

   // Encoded length per icode; 0 marks an invalid icode.
   function automatic logic [LW-1:0] f_len(input logic [3:0] icode);
      logic [LW-1:0] len;
      case (icode)
         4'h0, 4'h1, 4'h9:             len = LW'(1);
         4'h2, 4'h6, 4'hA, 4'hB:       len = LW'(2);
         4'h7, 4'h8:                   len = LW'(9);
         4'h3, 4'h4, 4'h5:             len = LW'(10);
         default:                      len = LW'(0);
      endcase
      return len;
   endfunction

   // Byte idx of the encoded instruction; valC is stored most significant byte first.
   function automatic logic [7:0] f_byte(input logic [3:0]    icode,
                                         input logic [3:0]    ifun,
                                         input logic [3:0]    ra,
                                         input logic [3:0]    rb,
                                         input logic [N-1:0]  valc,
                                         input logic [LW-1:0] idx);
      logic [7:0] b;
      logic [2:0] k;
      k = 3'd0;
      if (idx == LW'(0)) begin
         b = {icode, ifun};
      end else begin
         case (icode)
            4'h3, 4'h4, 4'h5: begin
               if (idx == LW'(1)) begin
                  b = {ra, rb};
               end else begin
                  k = 3'(idx - LW'(2));
                  b = valc[{3'(3'd7 - k), 3'b000} +: 8];
               end
            end
            4'h7, 4'h8: begin
               k = 3'(idx - LW'(1));
               b = valc[{3'(3'd7 - k), 3'b000} +: 8];
            end
            default: b = {ra, rb};
         endcase
      end
      return b;
   endfunction

   assign io_enc.in_ready  = (r_state == IDLE) && !io_enc.load_en && rst_n;
   assign io_enc.mem_we    = r_mem_we;
   assign io_enc.mem_addr  = r_mem_addr;
   assign io_enc.mem_wdata = r_mem_wdata;
   assign io_enc.wr_ptr    = r_wr_ptr;
   assign io_enc.done      = r_done;
   assign io_enc.enc_err   = r_enc_err;

   // Range check is done one bit wider than the pointer so a huge base cannot wrap into range.
   assign w_accept  = io_enc.in_valid && io_enc.in_ready;
   assign w_in_len  = f_len(io_enc.in_icode);
   assign w_in_end  = {1'b0, r_wr_ptr} + (N+1)'(w_in_len);
   assign w_idx_inc = r_idx + LW'(1);

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_wr_ptr    <= '0;
         r_base      <= '0;
         r_len       <= '0;
         r_idx       <= '0;
         r_icode     <= '0;
         r_ifun      <= '0;
         r_ra        <= '0;
         r_rb        <= '0;
         r_valc      <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_done      <= 1'b0;
         r_enc_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_wr_ptr    <= w_wr_ptr_nxt;
         r_base      <= w_base_nxt;
         r_len       <= w_len_nxt;
         r_idx       <= w_idx_nxt;
         r_icode     <= w_icode_nxt;
         r_ifun      <= w_ifun_nxt;
         r_ra        <= w_ra_nxt;
         r_rb        <= w_rb_nxt;
         r_valc      <= w_valc_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_done      <= w_done_nxt;
         r_enc_err   <= w_enc_err_nxt;
      end
   end

   // Next state and registered outputs. The first byte is driven at the accept edge so it is
   // visible the cycle after accept; each EMIT cycle then presents the following byte.
   always_comb begin
      w_state_nxt     = r_state;
      w_wr_ptr_nxt    = r_wr_ptr;
      w_base_nxt      = r_base;
      w_len_nxt       = r_len;
      w_idx_nxt       = r_idx;
      w_icode_nxt     = r_icode;
      w_ifun_nxt      = r_ifun;
      w_ra_nxt        = r_ra;
      w_rb_nxt        = r_rb;
      w_valc_nxt      = r_valc;
      w_mem_we_nxt    = 1'b0;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_done_nxt      = 1'b0;
      w_enc_err_nxt   = 1'b0;

      case (r_state)
         IDLE: begin
            if (io_enc.load_en) begin
               w_wr_ptr_nxt = io_enc.load_addr;
            end else if (w_accept) begin
               if ((w_in_len == LW'(0)) || (w_in_end > (N+1)'(MEM_BYTES))) begin
                  w_enc_err_nxt = 1'b1;
               end else begin
                  w_state_nxt     = EMIT;
                  w_base_nxt      = r_wr_ptr;
                  w_len_nxt       = w_in_len;
                  w_idx_nxt       = '0;
                  w_icode_nxt     = io_enc.in_icode;
                  w_ifun_nxt      = io_enc.in_ifun;
                  w_ra_nxt        = io_enc.in_rA;
                  w_rb_nxt        = io_enc.in_rB;
                  w_valc_nxt      = io_enc.in_valC;
                  w_mem_we_nxt    = 1'b1;
                  w_mem_addr_nxt  = AW'(r_wr_ptr);
                  w_mem_wdata_nxt = {io_enc.in_icode, io_enc.in_ifun};
                  w_done_nxt      = (w_in_len == LW'(1));
               end
            end
         end
         EMIT: begin
            if (r_idx == (r_len - LW'(1))) begin
               w_state_nxt  = IDLE;
               w_wr_ptr_nxt = r_base + N'(r_len);
            end else begin
               w_idx_nxt       = w_idx_inc;
               w_mem_we_nxt    = 1'b1;
               w_mem_addr_nxt  = AW'(r_base + N'(w_idx_inc));
               w_mem_wdata_nxt = f_byte(r_icode, r_ifun, r_ra, r_rb, r_valc, w_idx_inc);
               w_done_nxt      = (w_idx_inc == (r_len - LW'(1)));
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end
endmodule

// File: doc/imem_encoder.md
# imem_encoder

Instruction encoder and loader for the Y86-64 pipelined core: the write-side counterpart of the fetch stage. It accepts one decoded instruction (icode, ifun, rA, rB, valC) per handshake and serializes it into 1–10 bytes, written one byte per cycle through a byte-wide write port into the 1024-byte instruction memory. Byte layout matches what fetch reconstructs, so bytes written here decode back to the same fields.

## Interface
- n, 64, width of valC and the write pointer
- MEM_BYTES, 1024, instruction memory size in bytes; the address range is 0..MEM_BYTES-1
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_en  in  1  set the write pointer; honoured in IDLE only
- load_addr  in  n  new write pointer value
- in_valid  in  1  instruction fields are valid
- in_ready  out  1  combinational: (state==IDLE) && !load_en && rst_n
- in_icode, in_ifun, in_rA, in_rB  in  4 each  instruction fields
- in_valC  in  n  constant word or destination
- mem_we  out  1  registered byte write strobe
- mem_addr  out  10  registered byte address
- mem_wdata  out  8  registered byte data
- wr_ptr  out  n  address where the next instruction starts (its valP)
- done  out  1  one-cycle pulse coincident with the last byte write
- enc_err  out  1  one-cycle pulse: instruction rejected, nothing written

## Operation
- Length by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte
  - 2 cmovXX, 6 OPq, 10 pushq, 11 popq: 2 bytes
  - 7 jXX, 8 call: 9 bytes
  - 3 irmovq, 4 rmmovq, 5 mrmovq: 10 bytes
  - icode 12–15: invalid
- Byte 0 = {icode, ifun}.
- Register formats (icode 2–6, 10, 11): byte 1 = {rA, rB}. Fields are written verbatim; the caller supplies 4'hF for unused registers.
- icode 3/4/5: bytes 2..9 = valC[63:56], valC[55:48], …, valC[7:0] (most significant byte first).
- icode 7/8: bytes 1..8 = valC, most significant byte first. No register byte.
- FSM states: IDLE and EMIT.
  - IDLE, load_en: wr_ptr <= load_addr. load_en has priority over in_valid.
  - IDLE, accept (in_valid && in_ready): latch all fields, base = wr_ptr, len per the table, idx = 0.
  - On accept, the instruction is rejected if icode is invalid or base + len > MEM_BYTES (compared in n+1 bits, no wrap). A rejected instruction pulses enc_err next cycle, stays in IDLE, writes nothing, and leaves wr_ptr unchanged.
  - Otherwise the FSM moves to EMIT.
  - EMIT: each cycle drive mem_we=1, mem_addr=base+idx, mem_wdata=byte[idx], then idx++.
  - At idx == len-1, pulse done and go to IDLE with wr_ptr <= base + len.
- Writes are atomic with respect to range: a partially out-of-range instruction never writes any byte.
- load_en and in_valid are ignored during EMIT, and in_ready is low.

## Timing
- Reset values: state IDLE, wr_ptr 0, mem_we 0, mem_addr 0, mem_wdata 0, done 0, enc_err 0. in_ready is 0 while rst_n is low.
- Accept at edge T: first byte write is visible in cycle T+1; last byte in cycle T+len with done=1.
- in_ready returns high in cycle T+len+1. Throughput is len+1 cycles per instruction.
- Rejected instruction: enc_err high in cycle T+1 only. in_ready is high again in T+1, so back-to-back accepts are allowed.
- load_en at edge T: wr_ptr shows load_addr from T+1. An instruction offered in the same cycle is not accepted.
- Reset mid-EMIT: aborts immediately. Bytes already written remain in memory, mem_we drops asynchronously, and wr_ptr returns to 0.
- mem_we is never high outside EMIT.

## Test plan
- Reset, then encode irmovq (icode 3, ifun 0, rA F, rB 6, valC 64'h0A): bytes 30,F6,00,00,00,00,00,00,00,0A at addresses 0..9 over 10 cycles; done in the 10th cycle; wr_ptr=10.
- With wr_ptr=10, send jXX (icode 7, ifun 0, valC 64'h0102030405060708): bytes 70,01,02,…,08 at addresses 10..18; wr_ptr=19. Then send halt: byte 00 at 19; wr_ptr=20; done is asserted together with the single write.
- Send OPq (6,0,rA 2,rB 3) then pushq (A,0,rA 4,rB F) back-to-back: bytes 60,23 then A0,4F at consecutive addresses; in_ready low exactly 2 cycles after each accept.
- Range and validity errors:
  - load_addr=1020, then mrmovq (10 bytes) → enc_err pulse, mem_we never high, wr_ptr stays 1020.
  - Then nop → byte 10 at 1020, wr_ptr=1021.
  - icode 12 → enc_err, no write.
- Assert load_en and in_valid together in IDLE → in_ready=0, wr_ptr takes load_addr, no write. Pulse load_en during EMIT → ignored.
- Drop rst_n during byte 4 of an irmovq → mem_we falls without waiting for a clock edge; all outputs return to reset values; after release, wr_ptr=0 and in_ready=1.
